multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control decoder.
//  Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives all datapath enables.
//  Also drives the 2-bit ALUOp that the ALU control decoder expands with Funct.
//  Memory accesses use a ready handshake, so the FSM stalls on slow memory.
// PARAMETERS
//  RETIRE_W  32  width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1   system clock; all state changes on rising edge
//  reset        in   1   synchronous, active-high
//  Opcode       in   6   IR[31:26], sampled in DECODE
//  mem_ready    in   1   memory done this cycle (FETCH/MEM_READ/MEM_WRITE)
//  PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,ExtOp  out 1  datapath controls
//  PCSource     out  2   0=ALU result, 1=ALUOut (branch target), 2=jump target
//  ALUSrcB      out  2   0=B, 1=const 4, 2=extended imm, 3=sign-ext imm<<2
//  ALUOp        out  2   0=add, 1=AND, 2=use Funct (R-type), 3=subtract
//  state        out  4   current state code (debug)
//  illegal      out  1   high while in ILLEGAL
//  retire_count out  RETIRE_W  instructions completed since reset
// BEHAVIOUR
//  Reset: state<=FETCH(0), retire_count<=0. While reset=1 all write enables (PCWrite, PCWriteCond, MemWrite,
//   RegWrite, IRWrite) are forced 0. Reset mid-instruction abandons it and does not count it.
//  Outputs are Moore decodes of state, except the FETCH enables, which are gated by mem_ready. Unlisted outputs = 0.
//  Opcodes: R=0x00 lw=0x23 sw=0x2B beq=0x04 j=0x02 addi=0x08 andi=0x0C. All others, including ori=0x0D -> ILLEGAL.
//  0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
//   IRWrite=PCWrite=mem_ready. If mem_ready -> DECODE, else hold.
//  1 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state: lw/sw->2, R->6, beq->8, j->9, addi/andi->10, else->12.
//  2 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=0, ALUOp=0. lw->3, sw->5 (Opcode held stable by IR).
//  3 MEM_READ: MemRead=1, IorD=1. mem_ready -> 4, else hold.
//  4 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH; retire.
//  5 MEM_WRITE: MemWrite=1, IorD=1. mem_ready -> FETCH; retire. Else hold; MemWrite stays high.
//  6 EXECUTE: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> 7.
//  7 R_COMPLETE: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH; retire.
//  8 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=3, PCWriteCond=1, PCSource=1 -> FETCH; retire.
//  9 JUMP: PCWrite=1, PCSource=2 -> FETCH; retire.
//  10 IMM_EXEC: ALUSrcA=1, ALUSrcB=2. addi: ALUOp=0, ExtOp=0. andi: ALUOp=1, ExtOp=1 (zero-ext) -> 11.
//  11 IMM_COMPLETE: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH; retire.
//  12 ILLEGAL: illegal=1, all enables 0. Held until reset.
//  Unused codes 13-15 -> FETCH next cycle, no retire.
//  Retire: retire_count+1 on the edge leaving a completion state; wraps 2^RETIRE_W-1 -> 0.
//  Cycle counts at mem_ready=1: lw=5, sw=4, R=4, addi/andi=4, beq=3, j=3. Each stall cycle adds 1.
// TESTING
//  reset 2 cycles, mem_ready=1, Opcode=0x00 -> states 0,1,6,7,0; ALUOp=2 in state 6; RegWrite&RegDst in 7; retire_count=1.
//  lw (0x23), mem_ready low 3 cycles in MEM_READ -> state 3 held 4 cycles, then 4 with MemtoReg=1; total 8 cycles; count+1.
//  beq (0x04) -> state 8 with ALUOp=3, PCWriteCond=1, PCSource=1; andi (0x0C) -> state 10 with ALUOp=1, ExtOp=1.
//  Opcode=0x0D (ori) in DECODE -> state 12, illegal=1 held 10 cycles, no enables; reset -> FETCH, illegal=0.
//  reset asserted during MEM_WRITE with mem_ready=0 -> MemWrite=0 that cycle, state 0 next, count unchanged.
//  Force retire_count to 2^RETIRE_W-1 (RETIRE_W=4: 15), run j (0x02) -> count 0, PCSource=2, PCWrite=1 in state 9.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ============================================================================
//  multicycle_control_if
//  Bundles the opcode and memory-ready inputs with the datapath control,
//  debug and retire-count outputs of the multicycle control FSM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [5:0]          Opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                MemtoReg;
  logic                IRWrite;
  logic                ALUSrcA;
  logic                RegWrite;
  logic                RegDst;
  logic                ExtOp;
  logic [1:0]          PCSource;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [3:0]          state;
  logic                illegal;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ExtOp, PCSource, ALUSrcB, ALUOp,
           state, illegal, retire_count
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ExtOp, PCSource, ALUSrcB, ALUOp,
           state, illegal, retire_count
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  multicycle_control
//  Main control FSM of the multicycle MIPS datapath with memory-ready stalls
//  and a wrapping retired-instruction counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_control_if.master  bus
);

  localparam logic [3:0] c_fetch        = 4'd0;
  localparam logic [3:0] c_decode       = 4'd1;
  localparam logic [3:0] c_mem_addr     = 4'd2;
  localparam logic [3:0] c_mem_read     = 4'd3;
  localparam logic [3:0] c_mem_wb       = 4'd4;
  localparam logic [3:0] c_mem_write    = 4'd5;
  localparam logic [3:0] c_execute      = 4'd6;
  localparam logic [3:0] c_r_complete   = 4'd7;
  localparam logic [3:0] c_branch       = 4'd8;
  localparam logic [3:0] c_jump         = 4'd9;
  localparam logic [3:0] c_imm_exec     = 4'd10;
  localparam logic [3:0] c_imm_complete = 4'd11;
  localparam logic [3:0] c_illegal      = 4'd12;

  localparam logic [5:0] c_op_r    = 6'h00;
  localparam logic [5:0] c_op_lw   = 6'h23;
  localparam logic [5:0] c_op_sw   = 6'h2B;
  localparam logic [5:0] c_op_beq  = 6'h04;
  localparam logic [5:0] c_op_j    = 6'h02;
  localparam logic [5:0] c_op_addi = 6'h08;
  localparam logic [5:0] c_op_andi = 6'h0C;

  logic [3:0]          r_state;
  logic [3:0]          w_next_state;
  logic [RETIRE_W-1:0] r_retire_count;
  logic                w_retire;

  // Ungated write enables; reset masks them below.
  logic w_pc_write;
  logic w_pc_write_cond;
  logic w_mem_write;
  logic w_reg_write;
  logic w_ir_write;

  always_comb begin
    w_next_state    = c_fetch;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    w_ir_write      = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ExtOp       = 1'b0;
    bus.PCSource    = 2'd0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = 2'd0;
    bus.illegal     = 1'b0;

    case (r_state)
      c_fetch: begin
        bus.MemRead  = 1'b1;
        bus.ALUSrcB  = 2'd1;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_next_state = bus.mem_ready ? c_decode : c_fetch;
      end
      c_decode: begin
        bus.ALUSrcB = 2'd3;
        case (bus.Opcode)
          c_op_lw, c_op_sw:     w_next_state = c_mem_addr;
          c_op_r:               w_next_state = c_execute;
          c_op_beq:             w_next_state = c_branch;
          c_op_j:               w_next_state = c_jump;
          c_op_addi, c_op_andi: w_next_state = c_imm_exec;
          default:              w_next_state = c_illegal;
        endcase
      end
      c_mem_addr: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'd2;
        w_next_state = (bus.Opcode == c_op_sw) ? c_mem_write : c_mem_read;
      end
      c_mem_read: begin
        bus.MemRead  = 1'b1;
        bus.IorD     = 1'b1;
        w_next_state = bus.mem_ready ? c_mem_wb : c_mem_read;
      end
      c_mem_wb: begin
        w_reg_write  = 1'b1;
        bus.MemtoReg = 1'b1;
        w_retire     = 1'b1;
      end
      c_mem_write: begin
        w_mem_write  = 1'b1;
        bus.IorD     = 1'b1;
        w_retire     = bus.mem_ready;
        w_next_state = bus.mem_ready ? c_fetch : c_mem_write;
      end
      c_execute: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 2'd2;
        w_next_state = c_r_complete;
      end
      c_r_complete: begin
        w_reg_write = 1'b1;
        bus.RegDst  = 1'b1;
        w_retire    = 1'b1;
      end
      c_branch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'd3;
        w_pc_write_cond = 1'b1;
        bus.PCSource    = 2'd1;
        w_retire        = 1'b1;
      end
      c_jump: begin
        w_pc_write   = 1'b1;
        bus.PCSource = 2'd2;
        w_retire     = 1'b1;
      end
      c_imm_exec: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'd2;
        if (bus.Opcode == c_op_andi) begin
          bus.ALUOp = 2'd1;
          bus.ExtOp = 1'b1;
        end
        w_next_state = c_imm_complete;
      end
      c_imm_complete: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      c_illegal: begin
        bus.illegal  = 1'b1;
        w_next_state = c_illegal;
      end
      default: w_next_state = c_fetch;
    endcase
  end

  assign bus.PCWrite      = w_pc_write      & ~reset;
  assign bus.PCWriteCond  = w_pc_write_cond & ~reset;
  assign bus.MemWrite     = w_mem_write     & ~reset;
  assign bus.RegWrite     = w_reg_write     & ~reset;
  assign bus.IRWrite      = w_ir_write      & ~reset;
  assign bus.state        = r_state;
  assign bus.retire_count = r_retire_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_fetch;
      r_retire_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
